cmd_reg_loader: RTL and testbench

CMD_REG_LOADER -- requirements
Module: cmd_reg_loader

---
 rtl/cmd_reg_loader.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_cmd_reg_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_reg_loader.sv
// Command-frame register loader.
// Reads a frame from the command RAM and checks its 16-bit wrap-around checksum.
// If the checksum matches, it replays each three-word entry as one 32-bit register write.
// Data returned by the RAM is matched to its request by a valid tag RD_LAT stages deep.
module cmd_reg_loader #(
  parameter int RD_LAT    = 2,
  parameter int MAX_WORDS = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_frame_length,
  output logic [10:0] ram_addr_rx,
  output logic        ram_rd,
  input  logic [15:0] ram_dout_rx,
  output logic        reg_wr_valid,
  input  logic        reg_wr_ready,
  output logic [15:0] reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        err_csum,
  output logic [9:0]  entry_cnt,
  output logic        cmd_drop
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHK        = 3'd1,
    CHK_WAIT   = 3'd2,
    FETCH      = 3'd3,
    FETCH_WAIT = 3'd4,
    WRITE      = 3'd5,
    DONE       = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [10:0]       n_q, n_d;
  logic [10:0]       addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic [10:0]       ret_cnt_q, ret_cnt_d;
  logic [15:0]       sum_q, sum_d;
  logic [1:0]        sub_q, sub_d;
  logic [15:0]       ent_addr_q, ent_addr_d;
  logic [15:0]       ent_hi_q, ent_hi_d;
  logic              wr_valid_q, wr_valid_d;
  logic [15:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_len_q, err_len_d;
  logic              err_csum_q, err_csum_d;
  logic [9:0]        entry_cnt_q, entry_cnt_d;
  logic              drop_q, drop_d;

  logic              len_ok_s;
  logic              rvalid_s;

  // A length is usable only if it holds at least one entry plus a checksum and fits the RAM.
  assign len_ok_s = (cmd_frame_length >= 16'd4) &&
                    (cmd_frame_length <= 16'(MAX_WORDS)) &&
                    (((cmd_frame_length - 16'd1) % 16'd3) == 16'd0);

  // The oldest tag stage marks the cycle in which ram_dout_rx holds requested data.
  assign rvalid_s = tag_q[RD_LAT-1];

  // Shift the read-request flag down the tag pipe, one stage per clock.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = rd_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Next-state and datapath decode; every register defaults to holding its value.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    addr_d      = addr_q;
    rd_d        = 1'b0;
    ret_cnt_d   = ret_cnt_q;
    sum_d       = sum_q;
    sub_d       = sub_q;
    ent_addr_d  = ent_addr_q;
    ent_hi_d    = ent_hi_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_len_d   = err_len_q;
    err_csum_d  = err_csum_q;
    entry_cnt_d = entry_cnt_q;
    drop_d      = cmd_valid && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          entry_cnt_d = 10'd0;
          err_len_d   = 1'b0;
          err_csum_d  = 1'b0;
          if (len_ok_s) begin
            n_d       = cmd_frame_length[10:0];
            state_d   = CHK;
            rd_d      = 1'b1;
            addr_d    = 11'd0;
            ret_cnt_d = 11'd0;
            sum_d     = 16'd0;
          end else begin
            err_len_d = 1'b1;
            state_d   = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CHK: begin
        // Only words 0..N-2 can return while still issuing, so every return is summed here.
        if (addr_q == (n_q - 11'd1)) begin
          state_d = CHK_WAIT;
        end else begin
          rd_d   = 1'b1;
          addr_d = addr_q + 11'd1;
        end
        if (rvalid_s) begin
          sum_d     = sum_q + ram_dout_rx;
          ret_cnt_d = ret_cnt_q + 11'd1;
        end else begin
          sum_d = sum_q;
        end
      end

      CHK_WAIT: begin
        if (rvalid_s) begin
          if (ret_cnt_q == (n_q - 11'd1)) begin
            if (ram_dout_rx != sum_q) begin
              err_csum_d = 1'b1;
              state_d    = DONE;
            end else begin
              state_d   = FETCH;
              addr_d    = 11'd0;
              rd_d      = 1'b1;
              sub_d     = 2'd0;
              ret_cnt_d = 11'd0;
            end
          end else begin
            sum_d     = sum_q + ram_dout_rx;
            ret_cnt_d = ret_cnt_q + 11'd1;
          end
        end else begin
          state_d = CHK_WAIT;
        end
      end

      FETCH: begin
        if (sub_q == 2'd2) begin
          state_d = FETCH_WAIT;
        end else begin
          rd_d   = 1'b1;
          addr_d = addr_q + 11'd1;
          sub_d  = sub_q + 2'd1;
        end
        // The third word of an entry is never back before issuing ends.
        if (rvalid_s) begin
          if (ret_cnt_q == 11'd0) begin
            ent_addr_d = ram_dout_rx;
          end else begin
            ent_hi_d = ram_dout_rx;
          end
          ret_cnt_d = ret_cnt_q + 11'd1;
        end else begin
          ret_cnt_d = ret_cnt_q;
        end
      end

      FETCH_WAIT: begin
        if (rvalid_s) begin
          if (ret_cnt_q == 11'd2) begin
            wr_addr_d  = ent_addr_q;
            wr_data_d  = {ent_hi_q, ram_dout_rx};
            wr_valid_d = 1'b1;
            state_d    = WRITE;
          end else if (ret_cnt_q == 11'd1) begin
            ent_hi_d  = ram_dout_rx;
            ret_cnt_d = ret_cnt_q + 11'd1;
          end else begin
            ent_addr_d = ram_dout_rx;
            ret_cnt_d  = ret_cnt_q + 11'd1;
          end
        end else begin
          state_d = FETCH_WAIT;
        end
      end

      WRITE: begin
        wr_valid_d = 1'b1;
        if (wr_valid_q && reg_wr_ready) begin
          wr_valid_d  = 1'b0;
          entry_cnt_d = entry_cnt_q + 10'd1;
          // addr_q sits on the entry's last word; N-2 means the checksum word is next.
          if (addr_q == (n_q - 11'd2)) begin
            state_d = DONE;
          end else begin
            state_d   = FETCH;
            addr_d    = addr_q + 11'd1;
            rd_d      = 1'b1;
            sub_d     = 2'd0;
            ret_cnt_d = 11'd0;
          end
        end else begin
          state_d = WRITE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset returns the block to an idle, silent state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= 11'd0;
      addr_q      <= 11'd0;
      rd_q        <= 1'b0;
      tag_q       <= '0;
      ret_cnt_q   <= 11'd0;
      sum_q       <= 16'd0;
      sub_q       <= 2'd0;
      ent_addr_q  <= 16'd0;
      ent_hi_q    <= 16'd0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 16'd0;
      wr_data_q   <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_csum_q  <= 1'b0;
      entry_cnt_q <= 10'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      tag_q       <= tag_d;
      ret_cnt_q   <= ret_cnt_d;
      sum_q       <= sum_d;
      sub_q       <= sub_d;
      ent_addr_q  <= ent_addr_d;
      ent_hi_q    <= ent_hi_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      err_csum_q  <= err_csum_d;
      entry_cnt_q <= entry_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign ram_addr_rx  = addr_q;
  assign ram_rd       = rd_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_len      = err_len_q;
  assign err_csum     = err_csum_q;
  assign entry_cnt    = entry_cnt_q;
  assign cmd_drop     = drop_q;

endmodule

// File: tb/tb_cmd_reg_loader.sv
// Bench for cmd_reg_loader.
// Three instances run side by side (RD_LAT = 1, 2, 3), each with its own RAM read pipeline.
// Expected register writes are queued when a frame is loaded.
// They are compared against the writes each instance is seen to complete.
module tb_cmd_reg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] cmd_len;
  logic        wr_ready;

  logic        ram_rd_w   [3];
  logic [10:0] ram_addr_w [3];
  logic [15:0] dout_w     [3];
  logic        wr_valid_w [3];
  logic [15:0] wr_addr_w  [3];
  logic [31:0] wr_data_w  [3];
  logic        busy_w     [3];
  logic        done_w     [3];
  logic        err_len_w  [3];
  logic        err_csum_w [3];
  logic [9:0]  cnt_w      [3];
  logic        drop_w     [3];

  logic [15:0] mem  [0:2047];
  logic [15:0] pipe [3][3];

  logic [47:0] exp_q [$];
  logic [49:0] obs_q [$];

  int done_cnt [3];
  int rd_cnt   [3];
  int drop_cnt [3];
  int done_cyc [3];
  int base_done [3];
  int base_rd   [3];
  int base_drop [3];
  int cyc = 0;
  int cmd_cyc = 0;
  int vec_cnt = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cmd_reg_loader #(.RD_LAT(g + 1), .MAX_WORDS(2047)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_frame_length (cmd_len),
      .ram_addr_rx      (ram_addr_w[g]),
      .ram_rd           (ram_rd_w[g]),
      .ram_dout_rx      (dout_w[g]),
      .reg_wr_valid     (wr_valid_w[g]),
      .reg_wr_ready     (wr_ready),
      .reg_wr_addr      (wr_addr_w[g]),
      .reg_wr_data      (wr_data_w[g]),
      .busy             (busy_w[g]),
      .done             (done_w[g]),
      .err_len          (err_len_w[g]),
      .err_csum         (err_csum_w[g]),
      .entry_cnt        (cnt_w[g]),
      .cmd_drop         (drop_w[g])
    );
    assign dout_w[g] = pipe[g][g];
  end

  // RAM model: stage k holds data requested k+1 cycles ago; unrequested slots carry junk.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      pipe[g][0] <= ram_rd_w[g] ? mem[ram_addr_w[g]] : 16'hA5A5;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end

  // Monitor on the falling edge: completed writes, done pulses, reads and drops per instance.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (wr_valid_w[g] && wr_ready) obs_q.push_back({2'(g), wr_addr_w[g], wr_data_w[g]});
      if (done_w[g]) begin
        done_cnt[g] <= done_cnt[g] + 1;
        done_cyc[g] <= cyc;
      end
      if (ram_rd_w[g]) rd_cnt[g] <= rd_cnt[g] + 1;
      if (drop_w[g]) drop_cnt[g] <= drop_cnt[g] + 1;
    end
  end

  function automatic int obs_n(input int g);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][49:48] == 2'(g)) n++;
    return n;
  endfunction

  function automatic logic [47:0] obs_at(input int g, input int k);
    int n = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][49:48] == 2'(g)) begin
        if (n == k) return obs_q[i][47:0];
        n++;
      end
    end
    return 48'hFFFF_FFFF_FFFF;
  endfunction

  // Write up to two entries plus checksum into RAM; queue expected writes unless the checksum is corrupted.
  task automatic load_frame(input logic [47:0] e0, input logic [47:0] e1, input int ne, input bit bad);
    logic [15:0] s;
    logic [47:0] e;
    s = 16'd0;
    for (int i = 0; i < ne; i++) begin
      e = (i == 0) ? e0 : e1;
      mem[3*i]   = e[47:32];
      mem[3*i+1] = e[31:16];
      mem[3*i+2] = e[15:0];
      s = s + e[47:32] + e[31:16] + e[15:0];
      if (!bad) exp_q.push_back(e);
    end
    mem[3*ne] = bad ? (s + 16'd1) : s;
  endtask

  task automatic snap();
    for (int g = 0; g < 3; g++) begin
      base_done[g] = done_cnt[g];
      base_rd[g]   = rd_cnt[g];
      base_drop[g] = drop_cnt[g];
    end
  endtask

  task automatic pulse_cmd(input logic [15:0] n);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = n;
    cmd_cyc   = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done_cnt[0] > base_done[0] && done_cnt[1] > base_done[1] && done_cnt[2] > base_done[2]) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (wr_valid_w[0] && wr_valid_w[1] && wr_valid_w[2]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 16'd0; wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      vec_cnt++;
      if ({ram_rd_w[g], ram_addr_w[g], wr_valid_w[g], wr_addr_w[g], wr_data_w[g], busy_w[g], done_w[g],
           err_len_w[g], err_csum_w[g], cnt_w[g], drop_w[g]} !== 76'd0) begin
        miss_cnt++;
        $display("FAIL reset_outputs lat%0d: outputs not all zero", g + 1);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame(input int ne);
    bit ok;
    int n;
    wr_ready = 1'b1;
    if (ne == 2) load_frame({16'h0010, 32'h1234_5678}, {16'h0020, 32'hDEAD_BEEF}, 2, 1'b0);
    else load_frame({16'h0001, 32'hCAFE_F00D}, 48'd0, 1, 1'b0);
    n = 3 * ne + 1;
    snap();
    pulse_cmd(16'(n));
    wait_done(ok);
    vec_cnt++;
    if (ok !== 1'b1) begin miss_cnt++; $display("FAIL good_timeout N=%0d: done not seen", n); end
    for (int g = 0; g < 3; g++) begin
      vec_cnt++;
      if (obs_n(g) !== exp_q.size()) begin
        miss_cnt++; $display("FAIL good_wr_count lat%0d: got %0d want %0d", g + 1, obs_n(g), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_n(g); k++) begin
        vec_cnt++;
        if (obs_at(g, k) !== exp_q[k]) begin
          miss_cnt++; $display("FAIL good_wr lat%0d #%0d: got %h want %h", g + 1, k, obs_at(g, k), exp_q[k]);
        end
      end
      vec_cnt++;
      if ({err_len_w[g], err_csum_w[g], cnt_w[g], busy_w[g]} !== {1'b0, 1'b0, 10'(ne), 1'b0}) begin
        miss_cnt++;
        $display("FAIL good_status lat%0d: el=%b ec=%b cnt=%0d busy=%b want 0 0 %0d 0", g + 1,
                 err_len_w[g], err_csum_w[g], cnt_w[g], busy_w[g], ne);
      end
      vec_cnt++;
      if (done_cyc[g] - cmd_cyc < n + g + 2) begin
        miss_cnt++; $display("FAIL good_latency lat%0d: got %0d want >= %0d", g + 1, done_cyc[g] - cmd_cyc, n + g + 2);
      end
    end
    obs_q.delete();
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_bad_csum();
    bit ok;
    wr_ready = 1'b1;
    load_frame({16'h0010, 32'h1234_5678}, {16'h0020, 32'hDEAD_BEEF}, 2, 1'b1);
    snap();
    pulse_cmd(16'd7);
    wait_done(ok);
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (ok !== 1'b1) begin miss_cnt++; $display("FAIL csum_timeout: done not seen"); end
    for (int g = 0; g < 3; g++) begin
      vec_cnt++;
      if (rd_cnt[g] - base_rd[g] !== 7) begin
        miss_cnt++; $display("FAIL csum_reads lat%0d: got %0d want 7", g + 1, rd_cnt[g] - base_rd[g]);
      end
      vec_cnt++;
      if (obs_n(g) !== 0) begin miss_cnt++; $display("FAIL csum_writes lat%0d: got %0d want 0", g + 1, obs_n(g)); end
      vec_cnt++;
      if ({err_len_w[g], err_csum_w[g], cnt_w[g]} !== {1'b0, 1'b1, 10'd0}) begin
        miss_cnt++; $display("FAIL csum_flags lat%0d: el=%b ec=%b cnt=%0d want 0 1 0", g + 1,
                             err_len_w[g], err_csum_w[g], cnt_w[g]);
      end
      vec_cnt++;
      if (done_cyc[g] - cmd_cyc < 7 + g + 2) begin
        miss_cnt++; $display("FAIL csum_latency lat%0d: got %0d want >= %0d", g + 1, done_cyc[g] - cmd_cyc, 7 + g + 2);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_bad_len();
    bit ok;
    logic [15:0] lens [3];
    lens = '{16'd5, 16'd3, 16'd2050};
    for (int j = 0; j < 3; j++) begin
      snap();
      pulse_cmd(lens[j]);
      wait_done(ok);
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (ok !== 1'b1) begin miss_cnt++; $display("FAIL len_timeout N=%0d: done not seen", lens[j]); end
      for (int g = 0; g < 3; g++) begin
        vec_cnt++;
        if (done_cyc[g] - cmd_cyc !== 1) begin
          miss_cnt++; $display("FAIL len_latency N=%0d lat%0d: got %0d want 1", lens[j], g + 1, done_cyc[g] - cmd_cyc);
        end
        vec_cnt++;
        if ({rd_cnt[g] - base_rd[g], obs_n(g)} !== {32'd0, 32'd0}) begin
          miss_cnt++; $display("FAIL len_activity N=%0d lat%0d: reads %0d writes %0d want 0 0", lens[j], g + 1,
                               rd_cnt[g] - base_rd[g], obs_n(g));
        end
        vec_cnt++;
        if ({err_len_w[g], err_csum_w[g]} !== 2'b10) begin
          miss_cnt++; $display("FAIL len_flags N=%0d lat%0d: got %b%b want 10", lens[j], g + 1, err_len_w[g], err_csum_w[g]);
        end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_stall();
    bit ok;
    wr_ready = 1'b0;
    load_frame({16'h0010, 32'h1234_5678}, {16'h0020, 32'hDEAD_BEEF}, 2, 1'b0);
    snap();
    pulse_cmd(16'd7);
    wait_write(ok);
    vec_cnt++;
    if (ok !== 1'b1) begin miss_cnt++; $display("FAIL stall_reach_write: valid not seen"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        vec_cnt++;
        if ({wr_valid_w[g], wr_addr_w[g], wr_data_w[g]} !== {1'b1, 16'h0010, 32'h1234_5678}) begin
          miss_cnt++; $display("FAIL stall_hold c%0d lat%0d: got %b %h %h want 1 0010 12345678", c, g + 1,
                               wr_valid_w[g], wr_addr_w[g], wr_data_w[g]);
        end
      end
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    wait_done(ok);
    vec_cnt++;
    if (ok !== 1'b1) begin miss_cnt++; $display("FAIL stall_timeout: done not seen"); end
    for (int g = 0; g < 3; g++) begin
      vec_cnt++;
      if (obs_n(g) !== 2) begin miss_cnt++; $display("FAIL stall_wr_count lat%0d: got %0d want 2", g + 1, obs_n(g)); end
      for (int k = 0; k < exp_q.size() && k < obs_n(g); k++) begin
        vec_cnt++;
        if (obs_at(g, k) !== exp_q[k]) begin
          miss_cnt++; $display("FAIL stall_wr lat%0d #%0d: got %h want %h", g + 1, k, obs_at(g, k), exp_q[k]);
        end
      end
    end
    obs_q.delete();
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_drop();
    bit ok;
    wr_ready = 1'b1;
    load_frame({16'h0010, 32'h1234_5678}, {16'h0020, 32'hDEAD_BEEF}, 2, 1'b0);
    snap();
    pulse_cmd(16'd7);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = 16'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(ok);
    repeat (20) @(negedge clk);
    vec_cnt++;
    if (ok !== 1'b1) begin miss_cnt++; $display("FAIL drop_timeout: done not seen"); end
    for (int g = 0; g < 3; g++) begin
      vec_cnt++;
      if ({drop_cnt[g] - base_drop[g], done_cnt[g] - base_done[g]} !== {32'd1, 32'd1}) begin
        miss_cnt++; $display("FAIL drop_pulses lat%0d: drops %0d dones %0d want 1 1", g + 1,
                             drop_cnt[g] - base_drop[g], done_cnt[g] - base_done[g]);
      end
      vec_cnt++;
      if (obs_n(g) !== 2) begin miss_cnt++; $display("FAIL drop_wr_count lat%0d: got %0d want 2", g + 1, obs_n(g)); end
      for (int k = 0; k < exp_q.size() && k < obs_n(g); k++) begin
        vec_cnt++;
        if (obs_at(g, k) !== exp_q[k]) begin
          miss_cnt++; $display("FAIL drop_wr lat%0d #%0d: got %h want %h", g + 1, k, obs_at(g, k), exp_q[k]);
        end
      end
    end
    obs_q.delete();
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset_in_write();
    bit ok;
    wr_ready = 1'b0;
    load_frame({16'h0010, 32'h1234_5678}, {16'h0020, 32'hDEAD_BEEF}, 2, 1'b0);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    snap();
    pulse_cmd(16'd7);
    wait_write(ok);
    vec_cnt++;
    if (ok !== 1'b1) begin miss_cnt++; $display("FAIL rstw_reach_write: valid not seen"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    wr_ready = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      vec_cnt++;
      if ({ram_rd_w[g], ram_addr_w[g], wr_valid_w[g], wr_addr_w[g], wr_data_w[g], busy_w[g], done_w[g],
           err_len_w[g], err_csum_w[g], cnt_w[g], drop_w[g]} !== 76'd0) begin
        miss_cnt++; $display("FAIL rstw_outputs lat%0d: outputs not all zero during reset", g + 1);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      vec_cnt++;
      if ({busy_w[g], ram_rd_w[g], wr_valid_w[g], obs_n(g)} !== {3'b000, 32'd0}) begin
        miss_cnt++; $display("FAIL rstw_quiet lat%0d: busy=%b rd=%b vld=%b writes=%0d want all 0", g + 1,
                             busy_w[g], ram_rd_w[g], wr_valid_w[g], obs_n(g));
      end
    end
    obs_q.delete();
    test_good_frame(2);
  endtask

  initial begin
    test_reset();
    test_good_frame(2);
    test_good_frame(1);
    test_bad_csum();
    test_bad_len();
    test_stall();
    test_drop();
    test_reset_in_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
